stream_w_order_mux: RTL and testbench
=====================================

Name: stream_w_order_mux

Overview:
- Downstream companion to the AW-channel stream arbiter in the AXI write path.
- Records which input won each AW handshake in an in-order index FIFO.
- Routes the W bursts of the N_INP masters to a single W output in exactly that AW grant order, switching only after a beat with last=1.
- Keeps W data ordered with the arbitrated AW stream. Provides a full flag that gates the arbiter's output ready.

Parameters:
- N_INP, 2, number of W inputs; must equal the AW arbiter's N_INP; ≥2.
- DATA_WIDTH, 73, W payload width excluding the last bit (data+strb+user).
- MAX_TXNS, 4, index FIFO depth, i.e. outstanding AW grants whose W bursts are not yet complete; power of two, ≥2.
- IDX_WIDTH, $clog2(N_INP), derived; do not override.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- aw_hs_i  input  N_INP  per-input AW handshake vector (arbiter inp_valid_i & inp_ready_o); one-hot or zero
- aw_full_o  output  1  index FIFO full; the integrator ANDs ~aw_full_o into the arbiter oup_ready_i
- aw_overflow_o  output  1  one-cycle pulse: push attempted while full, push dropped
- inp_w_data_i  input  N_INP*DATA_WIDTH  W payloads, input i at [i*DATA_WIDTH +: DATA_WIDTH]
- inp_w_last_i  input  N_INP  W last per input
- inp_w_valid_i  input  N_INP  W valid per input
- inp_w_ready_o  output  N_INP  W ready per input
- oup_w_data_o  output  DATA_WIDTH  routed W payload
- oup_w_last_o  output  1  routed W last
- oup_w_valid_o  output  1  routed W valid
- oup_w_ready_i  input  1  downstream W ready

Behaviour:
- Reset (async assert, sync release): write/read pointers 0, count 0. aw_full_o=0, aw_overflow_o=0, oup_w_valid_o=0, inp_w_ready_o=0, oup_w_data_o=0, oup_w_last_o=0.
- Reset mid-burst discards all queued indices and any partial burst.
- Push:
  - Occurs on any cycle with |aw_hs_i=1.
  - Index = position of the lowest set bit; multi-hot input is tolerated, lowest index wins.
  - Write at wr_ptr; wr_ptr wraps modulo MAX_TXNS.
- Count:
  - Range 0..MAX_TXNS, IDX/count registers sized $clog2(MAX_TXNS)+1.
  - aw_full_o = (count==MAX_TXNS), combinational from the register.
- Push while full and no pop in the same cycle: entry dropped, pointers unchanged, aw_overflow_o=1 for exactly that cycle.
- Push while full with a pop in the same cycle: push accepted, count unchanged.
- Routing is valid only when count>0:
  - head = fifo[rd_ptr].
  - oup_w_valid_o = inp_w_valid_i[head].
  - oup_w_data_o / oup_w_last_o = fields of input head.
  - inp_w_ready_o[head] = oup_w_ready_i; all other ready bits 0.
  - All paths are combinational, zero-cycle latency.
- When count==0: oup_w_valid_o=0, oup_w_data_o=0, oup_w_last_o=0, inp_w_ready_o=0. W beats arriving before their AW grant stall.
- No bypass. An index pushed in cycle t becomes head at earliest in cycle t+1, even when the FIFO was empty. The W beat can therefore transfer no earlier than one cycle after its AW handshake.
- Pop:
  - Occurs when oup_w_valid_o & oup_w_ready_i & oup_w_last_o; rd_ptr advances (wrap modulo MAX_TXNS).
  - Beats with last=0 do not pop.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Consecutive bursts from the same input need one pop per AW grant; back-to-back transfer with no idle cycle is required when the next head is already valid.
- Valid from the selected input must not be dropped by this block. Once oup_w_valid_o is high, data is stable until accepted, given an AXI-compliant upstream.
- Width rules: index extraction is a priority encoder over N_INP bits; the output mux is indexed by head (IDX_WIDTH bits, head < N_INP always).

Test Plan:
- Reset, then aw_hs_i=2'b10 at cycle 1, input1 W 3 beats (last on 3rd), oup_w_ready_i=1 → no W transfer in cycle 1; beats out in cycles 2-4; inp_w_ready_o=2'b10 during them; count back to 0 at cycle 5; input0 ready stays 0 throughout.
- AW order 0,1,0 with all W inputs valid from start, 2-beat bursts, oup_w_ready_i=1 → output sequence in0,in0,in1,in1,in0,in0 with no idle cycles; last on beats 2, 4, 6.
- MAX_TXNS=4: 4 pushes with W stalled → aw_full_o=1; 5th push alone → aw_overflow_o pulses 1 cycle, count stays 4; next push coincident with a last-beat pop → accepted, count 4.
- oup_w_ready_i toggling 1,0,1,0 during a 4-beat burst from input 1 → oup_w_data_o/last held while ready=0; exactly 4 transfers; single pop after the 4th.
- Assert rst_ni low mid-burst with 3 queued indices → outputs 0 asynchronously, count 0; after release, W valid alone produces no oup_w_valid_o until a new AW push.
- aw_hs_i=2'b11 (illegal multi-hot) → index 0 pushed, one entry only.

Source files
------------

// File: rtl/stream_w_order_mux.sv
// W-channel order mux for the AXI write path.
// Routes W bursts in the order their AW handshakes were granted.
module stream_w_order_mux #(
    parameter int unsigned N_INP      = 2,
    parameter int unsigned DATA_WIDTH = 73,
    parameter int unsigned MAX_TXNS   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_INP-1:0]            aw_hs_i,
    output logic                        aw_full_o,
    output logic                        aw_overflow_o,
    input  logic [N_INP*DATA_WIDTH-1:0] inp_w_data_i,
    input  logic [N_INP-1:0]            inp_w_last_i,
    input  logic [N_INP-1:0]            inp_w_valid_i,
    output logic [N_INP-1:0]            inp_w_ready_o,
    output logic [DATA_WIDTH-1:0]       oup_w_data_o,
    output logic                        oup_w_last_o,
    output logic                        oup_w_valid_o,
    input  logic                        oup_w_ready_i
);

    localparam int unsigned IDX_WIDTH = (N_INP > 1) ? $clog2(N_INP) : 1;
    localparam int unsigned PTR_W     = $clog2(MAX_TXNS);
    localparam int unsigned CNT_W     = PTR_W + 1;

    logic [IDX_WIDTH-1:0] fifo_q [MAX_TXNS];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [IDX_WIDTH-1:0] push_idx;
    logic [IDX_WIDTH-1:0] head;
    logic                 push;
    logic                 push_ok;
    logic                 pop;
    logic                 empty;

    assign push      = |aw_hs_i;
    assign empty     = (count_q == '0);
    assign aw_full_o = (count_q == CNT_W'(MAX_TXNS));
    assign head      = fifo_q[rd_ptr_q];

    // Lowest set handshake bit wins, so multi-hot still pushes one index
    always_comb begin
        push_idx = '0;
        for (int i = int'(N_INP) - 1; i >= 0; i--) begin
            if (aw_hs_i[i]) push_idx = IDX_WIDTH'(i);
        end
    end

    // Head-selected W routing; everything idles while no grant is queued
    always_comb begin
        oup_w_valid_o = 1'b0;
        oup_w_data_o  = '0;
        oup_w_last_o  = 1'b0;
        inp_w_ready_o = '0;
        if (!empty) begin
            for (int i = 0; i < int'(N_INP); i++) begin
                if (head == IDX_WIDTH'(i)) begin
                    oup_w_valid_o    = inp_w_valid_i[i];
                    oup_w_data_o     = inp_w_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    oup_w_last_o     = inp_w_last_i[i];
                    inp_w_ready_o[i] = oup_w_ready_i;
                end
            end
        end
    end

    // A pop in the same cycle frees the slot a full-FIFO push needs
    always_comb begin
        pop           = oup_w_valid_o & oup_w_ready_i & oup_w_last_o;
        push_ok       = push & (~aw_full_o | pop);
        aw_overflow_o = push & aw_full_o & ~pop;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Index storage; contents are only observed while count is nonzero
    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_q[wr_ptr_q] <= push_idx;
    end

endmodule

// File: tb/tb_stream_w_order_mux.sv
// Randomized bench for stream_w_order_mux.
// A queue of granted indices predicts every output each cycle.
module tb_stream_w_order_mux;

    localparam int N  = 2;
    localparam int DW = 73;
    localparam int MT = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    aw_hs;
    logic            aw_full;
    logic            aw_ovf;
    logic [N*DW-1:0] w_data;
    logic [N-1:0]    w_last;
    logic [N-1:0]    w_valid;
    logic [N-1:0]    w_ready;
    logic [DW-1:0]   o_data;
    logic            o_last;
    logic            o_valid;
    logic            o_ready;

    int n_chk;
    int n_fail;
    int q[$];
    bit m_pop;
    bit m_push;

    stream_w_order_mux #(
        .N_INP(N),
        .DATA_WIDTH(DW),
        .MAX_TXNS(MT)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .aw_hs_i(aw_hs),
        .aw_full_o(aw_full),
        .aw_overflow_o(aw_ovf),
        .inp_w_data_i(w_data),
        .inp_w_last_i(w_last),
        .inp_w_valid_i(w_valid),
        .inp_w_ready_o(w_ready),
        .oup_w_data_o(o_data),
        .oup_w_last_o(o_last),
        .oup_w_valid_o(o_valid),
        .oup_w_ready_i(o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] slot(input int i);
        logic [N*DW-1:0] v;
        v = w_data >> (i * DW);
        return v[DW-1:0];
    endfunction

    // Compare outputs against the queue model, then plan the update
    task automatic model_check();
        logic [DW-1:0] ed;
        logic [N-1:0]  er;
        bit ev;
        bit el;
        bit full;
        int h;
        ed = '0;
        er = '0;
        ev = 0;
        el = 0;
        if (q.size() > 0) begin
            h  = q[0];
            ev = w_valid[h];
            el = w_last[h];
            ed = slot(h);
            er[h] = o_ready;
        end
        full   = (q.size() == MT);
        m_pop  = ev && o_ready && el;
        m_push = (aw_hs != '0);
        chk("valid", o_valid, ev);
        chk("data", o_data, ed);
        chk("last", o_last, el);
        chk("ready", w_ready, er);
        chk("full", aw_full, full);
        chk("ovf", aw_ovf, m_push && full && !m_pop);
    endtask

    task automatic model_update();
        int idx;
        bit full;
        full = (q.size() == MT);
        if (m_pop) void'(q.pop_front());
        if (m_push && (!full || m_pop)) begin
            idx = 0;
            while (!aw_hs[idx]) idx++;
            q.push_back(idx);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic rand_w();
        for (int i = 0; i < N; i++) begin
            w_data[i*DW +: DW] = DW'({$urandom, $urandom, $urandom});
        end
        w_valid = N'($urandom);
        w_last  = N'($urandom);
    endtask

    task automatic rand_aw();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55)      aw_hs = '0;
        else if (r < 60) aw_hs = 2'b11;
        else             aw_hs = N'(1 << $urandom_range(0, N - 1));
    endtask

    task automatic zero_outs(input string tag);
        chk({tag, "_valid"}, o_valid, 1'b0);
        chk({tag, "_data"}, o_data, '0);
        chk({tag, "_last"}, o_last, 1'b0);
        chk({tag, "_ready"}, w_ready, '0);
        chk({tag, "_full"}, aw_full, 1'b0);
        chk({tag, "_ovf"}, aw_ovf, 1'b0);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        aw_hs   = '0;
        w_data  = '0;
        w_last  = '0;
        w_valid = '0;
        o_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        zero_outs("rst");
        rst_n = 1'b1;

        // Single 3-beat burst from input 1
        aw_hs   = 2'b10;
        w_valid = 2'b10;
        w_last  = 2'b00;
        o_ready = 1'b1;
        rand_w();
        w_valid = 2'b10;
        w_last  = 2'b00;
        tick();
        aw_hs = '0;
        for (int b = 0; b < 3; b++) begin
            w_last = (b == 2) ? 2'b10 : 2'b00;
            #1 chk("b1_ready", w_ready, 2'b10);
            tick();
        end
        w_valid = '0;
        w_last  = '0;
        tick();
        chk("b1_empty", q.size(), 0);

        // Fill to full with W stalled, then overflow, then push+pop
        o_ready = 1'b0;
        w_valid = 2'b11;
        w_last  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            aw_hs = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
        end
        aw_hs = 2'b10;
        #1 chk("fill_full", aw_full, 1'b1);
        chk("fill_ovf", aw_ovf, 1'b1);
        tick();
        o_ready = 1'b1;
        #1 chk("pp_ovf", aw_ovf, 1'b0);
        tick();
        aw_hs = '0;
        #1 chk("pp_full", aw_full, 1'b1);
        repeat (6) tick();

        // Multi-hot handshake pushes only index 0
        aw_hs   = 2'b11;
        w_valid = 2'b00;
        tick();
        aw_hs = '0;
        chk("mh_size", q.size(), 1);
        w_valid = 2'b11;
        w_last  = 2'b11;
        #1 chk("mh_ready", w_ready, 2'b01);
        tick();
        tick();

        // Randomized traffic with an asynchronous reset in the middle
        for (int c = 0; c < 3000; c++) begin
            rand_aw();
            rand_w();
            o_ready = ($urandom_range(0, 99) < 45);
            if (c == 1500) begin
                aw_hs = '0;
                #2 rst_n = 1'b0;
                #1 zero_outs("arst");
                q.delete();
                @(posedge clk);
                #1 rst_n = 1'b1;
                w_valid = 2'b11;
                w_last  = 2'b11;
                o_ready = 1'b1;
                repeat (3) tick();
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
